// File: rtl/debug_dump_sequencer_pkg.sv
// Shared types for the post-run architectural-state dump engine:
// register index type, dump space tag, FSM states and the output beat layout.
package debug_dump_sequencer_pkg;

    localparam int REG_SIZE  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        DUMP_RF = 1'b0,
        DUMP_DM = 1'b1
    } dump_space_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RF_SWEEP,
        ST_DM_SWEEP,
        ST_DRAIN,
        ST_DONE
    } dump_state_e;

    typedef struct packed {
        dump_space_e         space;
        logic [REG_SIZE-1:0] index;
        logic [REG_SIZE-1:0] data;
    } dump_beat_t;

endpackage

// File: rtl/debug_dump_sequencer.sv
// Sweeps every register-file entry, then a window of data memory, through the
// pipeline debug read ports and streams one {space, index, data} beat per location.
module debug_dump_sequencer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int          RF_REGS  = 32,
    parameter logic [31:0] DM_BASE  = 32'h0,
    parameter int          DM_WORDS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output reg_idx_t            rf_debug_addr,
    input  logic [REG_SIZE-1:0] rf_debug_data,
    output logic [REG_SIZE-1:0] df_debug_addr,
    input  logic [REG_SIZE-1:0] df_debug_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_space,
    output logic [REG_SIZE-1:0] out_index,
    output logic [REG_SIZE-1:0] out_data,
    output logic                busy,
    output logic                done,
    output logic [REG_SIZE-1:0] checksum
);

    dump_state_e state, next_state;
    dump_beat_t  beat_q;
    logic [31:0] dm_cnt;
    logic        free, xfer, capture, rf_last, dm_last, launch;

    // The output slot can take a new beat when empty or when its beat leaves this edge.
    assign free    = !out_valid || out_ready;
    assign xfer    = out_valid && out_ready;
    assign launch  = (state == ST_IDLE) && start;
    assign rf_last = (rf_debug_addr == reg_idx_t'(RF_REGS - 1));
    assign dm_last = (dm_cnt == 32'(DM_WORDS - 1));

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_RF_SWEEP;
            end
            ST_RF_SWEEP: begin
                if (free) begin
                    capture = 1'b1;
                    if (rf_last) next_state = (DM_WORDS == 0) ? ST_DRAIN : ST_DM_SWEEP;
                end
            end
            ST_DM_SWEEP: begin
                if (free) begin
                    capture = 1'b1;
                    if (dm_last) next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q        <= '0;
            out_valid     <= 1'b0;
            rf_debug_addr <= '0;
            df_debug_addr <= '0;
            dm_cnt        <= '0;
            checksum      <= '0;
        end else begin
            if (launch) begin
                rf_debug_addr <= '0;
                df_debug_addr <= DM_BASE;
                dm_cnt        <= '0;
            end

            if (capture) begin
                out_valid <= 1'b1;
                if (state == ST_RF_SWEEP) begin
                    beat_q <= '{space: DUMP_RF, index: 32'(rf_debug_addr), data: rf_debug_data};
                    if (!rf_last) rf_debug_addr <= rf_debug_addr + 1'b1;
                end else begin
                    beat_q <= '{space: DUMP_DM, index: df_debug_addr, data: df_debug_data};
                    if (!dm_last) begin
                        df_debug_addr <= df_debug_addr + 32'd4;
                        dm_cnt        <= dm_cnt + 32'd1;
                    end
                end
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            // A launch only happens from IDLE, where the slot is always empty.
            if (launch) begin
                checksum <= '0;
            end else if (xfer) begin
                checksum <= checksum ^ beat_q.data;
            end
        end
    end

    assign out_space = beat_q.space;
    assign out_index = beat_q.index;
    assign out_data  = beat_q.data;
    assign busy      = (state == ST_RF_SWEEP) || (state == ST_DM_SWEEP) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

endmodule
